// File: rtl/nn_rnn_step_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : nn_rnn_step_seq_if
// Brief    : Control/status bundle between the RNN timestep sequencer and its host.
// Revision : 1.0  initial release
// ============================================================================
interface nn_rnn_step_seq_if #(
    parameter int NR = 4,
    parameter int W  = 8,
    parameter int SW = 6
);
    logic              start;
    logic              abort;
    logic [SW-1:0]     n_steps;
    logic [W-1:0]      stream_len;
    logic [NR-1:0]     a_out;
    logic              node_init;
    logic              init_state;
    logic [SW-1:0]     step_idx;
    logic [NR*W-1:0]   a_count;
    logic              count_valid;
    logic              busy;
    logic              done;

    modport master (
        output start, abort, n_steps, stream_len, a_out,
        input  node_init, init_state, step_idx, a_count, count_valid, busy, done
    );

    modport slave (
        input  start, abort, n_steps, stream_len, a_out,
        output node_init, init_state, step_idx, a_count, count_valid, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/nn_rnn_step_seq.sv
`default_nettype none
// ============================================================================
// Module   : nn_rnn_step_seq
// Brief    : Runs a recurrent layer for n_steps timesteps of stream_len cycles,
//            counting ones per node and publishing the counts each timestep.
// Revision : 1.0  initial release
// ============================================================================
module nn_rnn_step_seq #(
    parameter int NR = 4,
    parameter int W  = 8,
    parameter int SW = 6
) (
    input  logic             CLK,
    input  logic             INIT,
    nn_rnn_step_seq_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CLR  = 3'd1,
        S_RUN  = 3'd2,
        S_CAPT = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [W-1:0]  c_cnt_max = '1;
    localparam logic [W-1:0]  c_w_one   = W'(1);
    localparam logic [SW-1:0] c_sw_one  = SW'(1);

    state_t               r_state;
    state_t               w_state_next;
    logic [SW-1:0]        r_n_steps;
    logic [SW-1:0]        r_step_idx;
    logic [W-1:0]         r_stream_len;
    logic [W-1:0]         r_cyc;
    logic [NR-1:0][W-1:0] r_ones;
    logic [NR*W-1:0]      r_a_count;
    logic [NR*W-1:0]      w_ones_flat;
    logic                 w_accept;
    logic                 w_last_cyc;
    logic                 w_last_step;
    logic                 w_load;
    logic                 w_active;

    assign w_accept    = bus.start && !bus.abort &&
                         (bus.n_steps != '0) && (bus.stream_len != '0);
    assign w_last_cyc  = (r_cyc == (r_stream_len - c_w_one));
    assign w_last_step = (r_step_idx == (r_n_steps - c_sw_one));
    // Abort in CAPT suppresses the publish, so the load is gated here.
    assign w_load      = (r_state == S_CAPT) && !bus.abort;
    assign w_active    = (r_state == S_CLR) || (r_state == S_RUN) || (r_state == S_CAPT);
    assign w_ones_flat = r_ones;

    always_ff @(posedge CLK) begin
        if (INIT) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = S_CLR;
                end
            end
            S_CLR: begin
                w_state_next = bus.abort ? S_IDLE : S_RUN;
            end
            S_RUN: begin
                if (bus.abort) begin
                    w_state_next = S_IDLE;
                end else if (w_last_cyc) begin
                    w_state_next = S_CAPT;
                end
            end
            S_CAPT: begin
                if (bus.abort) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_state_next = w_last_step ? S_DONE : S_CLR;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (INIT) begin
            r_n_steps    <= '0;
            r_stream_len <= '0;
            r_step_idx   <= '0;
            r_cyc        <= '0;
            r_ones       <= '0;
            r_a_count    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_n_steps    <= bus.n_steps;
                        r_stream_len <= bus.stream_len;
                        r_step_idx   <= '0;
                    end
                end
                S_CLR: begin
                    r_cyc  <= '0;
                    r_ones <= '0;
                end
                S_RUN: begin
                    r_cyc <= r_cyc + c_w_one;
                    for (int i = 0; i < NR; i++) begin
                        if (bus.a_out[i] && (r_ones[i] != c_cnt_max)) begin
                            r_ones[i] <= r_ones[i] + c_w_one;
                        end
                    end
                end
                S_CAPT: begin
                    if (w_load) begin
                        r_a_count <= w_ones_flat;
                        if (!w_last_step) begin
                            r_step_idx <= r_step_idx + c_sw_one;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // The new counts are forwarded during CAPT so a_count changes with count_valid.
    assign bus.a_count     = w_load ? w_ones_flat : r_a_count;
    assign bus.count_valid = w_load;
    assign bus.node_init   = (r_state == S_CLR);
    assign bus.init_state  = w_active && (r_step_idx == '0);
    assign bus.step_idx    = r_step_idx;
    assign bus.busy        = w_active;
    assign bus.done        = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_nn_rnn_step_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_nn_rnn_step_seq
// Brief    : Directed self-checking bench for the RNN timestep sequencer.
// Revision : 1.0  initial release
// ============================================================================
module tb_nn_rnn_step_seq;
    localparam int NR = 4;
    localparam int W  = 8;
    localparam int SW = 6;

    logic clk  = 1'b0;
    logic init = 1'b1;
    always #5 clk = ~clk;

    nn_rnn_step_seq_if #(.NR(NR), .W(W), .SW(SW)) bus ();

    nn_rnn_step_seq #(.NR(NR), .W(W), .SW(SW)) dut (
        .CLK  (clk),
        .INIT (init),
        .bus  (bus)
    );

    int              n_err = 0;
    int              n_chk = 0;
    logic [NR*W-1:0] exp_acnt   = '0;
    logic [SW-1:0]   exp_step   = '0;
    bit              step_known = 1'b1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic b, input logic ni, input logic is,
                           input logic cv, input logic dn, input logic [SW-1:0] st,
                           input logic [NR*W-1:0] ac);
        chk({tag, ".busy"},        64'(bus.busy),        64'(b));
        chk({tag, ".node_init"},   64'(bus.node_init),   64'(ni));
        chk({tag, ".init_state"},  64'(bus.init_state),  64'(is));
        chk({tag, ".count_valid"}, 64'(bus.count_valid), 64'(cv));
        chk({tag, ".done"},        64'(bus.done),        64'(dn));
        chk({tag, ".step_idx"},    64'(bus.step_idx),    64'(st));
        chk({tag, ".a_count"},     64'(bus.a_count),     64'(ac));
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    task automatic to_mid();
        @(negedge clk);
    endtask

    // One start request; kill_t>0 aborts (or resets when kill_init) in that cycle.
    task automatic run_seq(input int ns, input int len, input logic [NR-1:0] a,
                           input bit hold, input int kill_t, input bit kill_init);
        int              p;
        int              tend;
        int              s;
        int              ph;
        bit              last;
        bit              capt;
        logic [NR*W-1:0] new_acnt;
        logic [NR*W-1:0] cur;
        logic [W-1:0]    len_w;
        p     = len + 2;
        tend  = ns * p + 1;
        len_w = len[W-1:0];
        for (int i = 0; i < NR; i++) new_acnt[i*W +: W] = a[i] ? len_w : '0;
        cur = exp_acnt;

        bus.start      = 1'b1;
        bus.abort      = 1'b0;
        bus.n_steps    = SW'(ns);
        bus.stream_len = len_w;
        bus.a_out      = a;
        to_mid();
        chk("idle.busy", 64'(bus.busy), 64'(0));
        chk("idle.a_count", 64'(bus.a_count), 64'(exp_acnt));
        if (step_known) chk("idle.step_idx", 64'(bus.step_idx), 64'(exp_step));
        edge_step();
        if (!hold) begin
            bus.start      = 1'b0;
            bus.n_steps    = SW'(1);
            bus.stream_len = W'(1);
        end

        for (int t = 1; t <= tend; t++) begin
            s    = (t - 1) / p;
            ph   = (t - 1) % p;
            last = (t == tend);
            capt = !last && (ph == len + 1);
            if (t == kill_t) begin
                if (kill_init) init = 1'b1;
                else           bus.abort = 1'b1;
                to_mid();
                if (!kill_init) begin
                    chk("abort.count_valid", 64'(bus.count_valid), 64'(0));
                    chk("abort.done",        64'(bus.done),        64'(0));
                    chk("abort.a_count",     64'(bus.a_count),     64'(cur));
                end
                edge_step();
                init      = 1'b0;
                bus.abort = 1'b0;
                to_mid();
                chk("kill.busy",        64'(bus.busy),        64'(0));
                chk("kill.node_init",   64'(bus.node_init),   64'(0));
                chk("kill.init_state",  64'(bus.init_state),  64'(0));
                chk("kill.count_valid", 64'(bus.count_valid), 64'(0));
                chk("kill.done",        64'(bus.done),        64'(0));
                chk("kill.a_count",     64'(bus.a_count),     64'(kill_init ? '0 : cur));
                if (kill_init) chk("kill.step_idx", 64'(bus.step_idx), 64'(0));
                exp_acnt   = kill_init ? '0 : cur;
                exp_step   = '0;
                step_known = kill_init;
                edge_step();
                return;
            end
            to_mid();
            if (last)
                chk_all("done", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, SW'(ns - 1), new_acnt);
            else
                chk_all(capt ? "capt" : ((ph == 0) ? "clr" : "run"), 1'b1, (ph == 0),
                        (s == 0), capt, 1'b0, SW'(s), capt ? new_acnt : cur);
            if (capt) cur = new_acnt;
            edge_step();
        end
        exp_acnt   = new_acnt;
        exp_step   = SW'(ns - 1);
        step_known = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        bus.n_steps    = '0;
        bus.stream_len = '0;
        bus.a_out      = '0;
        init           = 1'b1;
        edge_step();
        edge_step();
        to_mid();
        chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        edge_step();
        init = 1'b0;
        edge_step();

        // Single step, alternating nodes active: counts {0,10,0,10}
        run_seq(1, 10, 4'b0101, 1'b0, 0, 1'b0);
        // Three steps, all nodes active, period 6
        run_seq(3, 4, 4'b1111, 1'b0, 0, 1'b0);
        // Longest stream: counts reach 255 without wrapping
        run_seq(1, 255, 4'b1111, 1'b0, 0, 1'b0);

        // Rejected starts: zero n_steps, zero stream_len, start together with abort
        bus.start = 1'b1; bus.n_steps = SW'(0); bus.stream_len = W'(5);
        edge_step(); to_mid();
        chk("rej_n0.busy", 64'(bus.busy), 64'(0));
        chk("rej_n0.node_init", 64'(bus.node_init), 64'(0));
        edge_step();
        bus.n_steps = SW'(3); bus.stream_len = W'(0);
        edge_step(); to_mid();
        chk("rej_l0.busy", 64'(bus.busy), 64'(0));
        edge_step();
        bus.stream_len = W'(5); bus.abort = 1'b1;
        edge_step(); to_mid();
        chk("rej_abort.busy", 64'(bus.busy), 64'(0));
        chk("rej_abort.a_count", 64'(bus.a_count), 64'(exp_acnt));
        edge_step();
        bus.abort = 1'b0; bus.start = 1'b0;
        edge_step();

        // Abort in the CAPT cycle of step 1 of 3 (t = 2*(4+2))
        run_seq(3, 4, 4'b0110, 1'b0, 12, 1'b0);
        // INIT mid-RUN, then a normal full sequence
        run_seq(2, 6, 4'b1001, 1'b0, 4, 1'b1);
        run_seq(2, 3, 4'b0011, 1'b0, 0, 1'b0);
        // start held through a sequence: the next is accepted right after DONE
        run_seq(1, 5, 4'b1100, 1'b1, 0, 1'b0);
        run_seq(2, 2, 4'b0110, 1'b0, 0, 1'b0);
        to_mid();
        chk_all("final_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, SW'(1), exp_acnt);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
